regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-issue register file.
- Adds N combinational read ports with write-to-read bypass.
- Adds a per-register pending-write scoreboard (saturating counters) so the execute stage can detect RAW hazards and the issue side can throttle WAW depth.
- Adds a flush input for branch-mispredict recovery.
- Sits between decode/execute (issue and read side) and writeback (write side) in the core pipeline.

Parameters:
XLEN, 32, data width of each architectural register
NREGS, 32, number of architectural registers; register 0 is hardwired to zero
NREAD, 2, number of independent read ports
PEND_W, 2, width of each per-register pending counter; max in-flight writes per register = 2^PEND_W-1
AW, $clog2(NREGS), register address width (derived, not overridable)

Ports:
clk  in  1  clock, all state rising-edge
rst  in  1  asynchronous active-low reset
rd_addr  in  NREAD*AW  packed read addresses, port i at [i*AW +: AW]
rd_data  out  NREAD*XLEN  packed read data, combinational
rd_ready  out  NREAD  per-port: operand value is architecturally final this cycle
iss_valid  in  1  issuing instruction will write iss_rd
iss_rd  in  AW  destination register of issuing instruction
iss_ready  out  1  issue accepted this cycle if iss_valid (pending counter not saturated)
wb_valid  in  1  writeback commits wb_data to wb_rd
wb_rd  in  AW  writeback destination
wb_data  in  XLEN  writeback value
flush  in  1  discard all in-flight writes: clear every pending counter
busy_any  out  1  registered: some pending counter nonzero

Behaviour:
- Reset (rst=0, async): all registers 0, all pending counters 0, busy_any=0. Combinational outputs follow from the cleared state: rd_data=0, rd_ready=all 1, iss_ready=1.
- Read (0-cycle latency), per port i, addr a:
  - a==0: rd_data=0, rd_ready=1.
  - else if wb_valid && wb_rd==a: rd_data=wb_data (bypass).
  - else: rd_data=reg[a].
- rd_ready[i]:
  - pend[a]==0, or
  - pend[a]==1 && wb_valid && wb_rd==a && !flush-independent (bypass delivers the final value).
  - pend[a]>=2 with a writeback this cycle: rd_ready=0, because an older write completes but a younger one is still outstanding.
- Write: on clk rising edge, if wb_valid && wb_rd!=0, reg[wb_rd] <= wb_data. Writes to 0 are ignored.
- iss_ready = (iss_rd==0) || (pend[iss_rd] != 2^PEND_W-1). The issue is accepted when iss_valid && iss_ready.
- Pending counter update per register r != 0, at the clock edge:
  - flush=1: pend <= 0 for all registers. Flush has priority over simultaneous issue and writeback. The data write from a simultaneous writeback still occurs.
  - accepted issue to r and wb to r in the same cycle: pend unchanged.
  - accepted issue only: pend+1 (cannot overflow, guaranteed by iss_ready).
  - wb only: pend-1, saturating at 0. A stale writeback after a flush writes data and leaves pend at 0, with no underflow.
- Register 0 counter is always 0; issue and writeback to register 0 are no-ops.
- busy_any: registered OR of all next-state pending counters; updates one cycle after the causing event.
- No X propagation: out-of-range addresses (>= NREGS when NREGS is not a power of 2) read 0 with rd_ready=1, and writes to them are ignored.

Decomposition:
- Package core_pkg gains:
  - localparam REG_ZERO = '0
  - typedef logic [PEND_W-1:0] pend_cnt_t
  - a function pend_next(cnt, inc, dec, flush) shared with the verification model.
- A single sub-module, regfile_read_port (one instance per read port via generate), holds the bypass mux plus the rd_ready logic.
- Storage and counters stay in the parent.

Test Plan:
- Reset then read ports at addrs 5,0 -> rd_data 0/0, rd_ready 1/1, iss_ready=1, busy_any=0.
- Issue rd=5; next cycle read 5 -> rd_ready=0. Then wb_valid rd=5 data=0xDEADBEEF in the same cycle as the read -> rd_data=0xDEADBEEF, rd_ready=1. Following cycle: reg[5]=0xDEADBEEF, busy_any=0.
- PEND_W=2: issue rd=7 three times -> iss_ready=0 for rd=7 while iss_rd=7, and still 1 for iss_rd=8. One wb to 7 -> iss_ready=1, pend=2. Read 7 with a simultaneous wb -> rd_ready=0.
- Same-cycle issue and wb to rd=3 with pend=1 -> pend stays 1 and rd_ready stays 0 afterwards.
- Issue rd=9,10 then flush with a simultaneous wb rd=9 data=0x55 -> all pend 0, reg[9]=0x55, busy_any=0 next cycle. Later stale wb rd=10 data=0x66 -> reg[10]=0x66, pend[10]=0.
- Writes and issues to register 0 (wb data 0xFFFFFFFF) -> reads of 0 return 0 and rd_ready=1. Assert rst low mid-sequence -> all state clears immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and helpers for the register file with pending-write scoreboard.
// The pending-counter update rule lives here so every user agrees on it.
package core_pkg;

    localparam int unsigned REG_ZERO    = '0;
    localparam int unsigned PEND_W_DFLT = 2;

    typedef logic [PEND_W_DFLT-1:0] pend_cnt_t;

    // Width-agnostic next value of one pending counter. Flush wins over
    // everything; an issue and a writeback in the same cycle cancel; a
    // writeback with nothing pending (stale after flush) leaves zero.
    function automatic int unsigned pend_next(
        input int unsigned cnt,
        input logic        inc,
        input logic        dec,
        input logic        flush
    );
        int unsigned nxt;
        nxt = cnt;
        if (flush) begin
            nxt = 0;
        end else if (inc && !dec) begin
            nxt = cnt + 1;
        end else if (dec && !inc) begin
            nxt = (cnt == 0) ? 0 : cnt - 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: zero/out-of-range handling, writeback bypass
// and the operand-ready decision against the pending-write count.
module regfile_read_port
    import core_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int PEND_W = 2,
    parameter int AW     = 5
) (
    input  logic [AW-1:0]     rd_addr,
    input  logic [XLEN-1:0]   reg_val,
    input  logic [PEND_W-1:0] pend_val,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   rd_data,
    output logic              rd_ready
);

    logic addr_const_zero;
    logic wb_hit;

    assign addr_const_zero = (int'(rd_addr) == int'(REG_ZERO)) || (int'(rd_addr) >= NREGS);
    assign wb_hit          = wb_valid && (wb_rd == rd_addr);

    // NOTE: every output gets a default first, so no path through this block can infer a latch.
    always_comb begin
        rd_data  = '0;
        rd_ready = 1'b1;
        if (!addr_const_zero) begin
            rd_data  = wb_hit ? wb_data : reg_val;
            // With two or more writes outstanding, the one completing now is
            // not the youngest, so the bypassed value is not yet final.
            rd_ready = (pend_val == '0) || ((pend_val == PEND_W'(1)) && wb_hit);
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with N bypassed read ports and a per-register saturating
// pending-write scoreboard for RAW detection, WAW throttling and flush.
module regfile_scoreboard
    import core_pkg::*;
#(
    parameter  int XLEN   = 32,
    parameter  int NREGS  = 32,
    parameter  int NREAD  = 2,
    parameter  int PEND_W = 2,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_ready,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    output logic                  iss_ready,
    input  logic                  wb_valid,
    input  logic [AW-1:0]         wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  flush,
    output logic                  busy_any
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [XLEN-1:0]   regs_q [NREGS];
    logic [XLEN-1:0]   regs_d [NREGS];
    logic [PEND_W-1:0] pend_q [NREGS];
    logic [PEND_W-1:0] pend_d [NREGS];
    logic              busy_any_q;
    logic              busy_any_d;

    logic              wb_writable;
    logic              iss_trackable;
    logic              iss_fire;

    // Register 0 and addresses beyond NREGS carry no state.
    assign wb_writable   = wb_valid && (int'(wb_rd) != int'(REG_ZERO)) && (int'(wb_rd) < NREGS);
    assign iss_trackable = (int'(iss_rd) != int'(REG_ZERO)) && (int'(iss_rd) < NREGS);
    assign iss_ready     = !(iss_trackable && (pend_q[iss_rd] == PEND_MAX));
    assign iss_fire      = iss_valid && iss_ready && iss_trackable;

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        if (wb_writable) begin
            regs_d[wb_rd] = wb_data;
        end
    end

    always_comb begin
        busy_any_d = 1'b0;
        pend_d[0]  = '0;
        for (int r = 1; r < NREGS; r++) begin
            pend_d[r] = PEND_W'(pend_next(32'(pend_q[r]),
                                          iss_fire && (int'(iss_rd) == r),
                                          wb_valid && (int'(wb_rd) == r),
                                          flush));
            busy_any_d = busy_any_d || (pend_d[r] != '0);
        end
    end

    // NOTE: storage is reset along with the counters because software may
    // read any register right after reset and must see zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
            busy_any_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
                pend_q[r] <= pend_d[r];
            end
            busy_any_q <= busy_any_d;
        end
    end

    assign busy_any = busy_any_q;

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]     port_addr;
        logic [XLEN-1:0]   port_reg;
        logic [PEND_W-1:0] port_pend;

        assign port_addr = rd_addr[i*AW +: AW];
        assign port_reg  = (int'(port_addr) < NREGS) ? regs_q[port_addr] : '0;
        assign port_pend = (int'(port_addr) < NREGS) ? pend_q[port_addr] : '0;

        regfile_read_port #(
            .XLEN   (XLEN),
            .NREGS  (NREGS),
            .PEND_W (PEND_W),
            .AW     (AW)
        ) u_port (
            .rd_addr  (port_addr),
            .reg_val  (port_reg),
            .pend_val (port_pend),
            .wb_valid (wb_valid),
            .wb_rd    (wb_rd),
            .wb_data  (wb_data),
            .rd_data  (rd_data[i*XLEN +: XLEN]),
            .rd_ready (rd_ready[i])
        );
    end

endmodule
